// File: rtl/keypad_code_entry_pkg.sv
// Shared definitions for the keypad code-entry path: special key codes,
// the matrix position to key value map, and the scan FSM states.
package keypad_code_entry_pkg;

  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_ENT = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } scan_state_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    v = 4'h0;
    case ({row, col})
      4'h0: v = 4'h1;
      4'h1: v = 4'h2;
      4'h2: v = 4'h3;
      4'h3: v = 4'hA;
      4'h4: v = 4'h4;
      4'h5: v = 4'h5;
      4'h6: v = 4'h6;
      4'h7: v = 4'hB;
      4'h8: v = 4'h7;
      4'h9: v = 4'h8;
      4'hA: v = 4'h9;
      4'hB: v = 4'hC;
      4'hC: v = KEY_CLR;
      4'hD: v = 4'h0;
      4'hE: v = KEY_ENT;
      4'hF: v = 4'hD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/keypad_debounce_scan.sv
// Column scanner and press/release debouncer for a 4x4 active-low keypad.
// Emits a single-cycle key_event with the key value when a press is accepted.
module keypad_debounce_scan
  import keypad_code_entry_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_event,
  output logic [3:0] key_value
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx, col_idx_n;
  logic [1:0]       key_row, key_row_n;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_n;
  scan_state_t      state, state_n;
  logic             event_n;
  logic [3:0]       value_n;
  logic             sample, any_low, same_key;
  logic [1:0]       low_row;

  assign sample   = (div_cnt == DIV_LAST);
  assign any_low  = ~&row_s2;
  assign same_key = any_low && (low_row == key_row);

  // Lowest row index wins when several rows are pulled low together.
  always_comb begin
    low_row = 2'd3;
    if (!row_s2[2]) low_row = 2'd2;
    if (!row_s2[1]) low_row = 2'd1;
    if (!row_s2[0]) low_row = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      div_cnt <= '0;
    end else begin
      row_s1  <= row_in;
      row_s2  <= row_s1;
      div_cnt <= sample ? '0 : div_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    key_row_n = key_row;
    deb_cnt_n = deb_cnt;
    event_n   = 1'b0;
    value_n   = key_value;
    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (any_low) begin
            key_row_n = low_row;
            deb_cnt_n = DEB_W'(1);
            state_n   = ST_DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (same_key) begin
            if (deb_cnt == DEB_LAST) begin
              state_n = ST_HELD;
              event_n = 1'b1;
              value_n = key_map(key_row, col_idx);
            end else begin
              deb_cnt_n = deb_cnt + 1'b1;
            end
          end else begin
            state_n   = ST_SCAN;
            col_idx_n = col_idx + 1'b1;
          end
        end
        ST_HELD: begin
          if (!any_low) begin
            state_n   = ST_RELEASE;
            deb_cnt_n = DEB_W'(1);
          end
        end
        ST_RELEASE: begin
          if (any_low) begin
            state_n = ST_HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state_n   = ST_SCAN;
            col_idx_n = col_idx + 1'b1;
          end else begin
            deb_cnt_n = deb_cnt + 1'b1;
          end
        end
        default: state_n = ST_SCAN;
      endcase
    end
  end

  // Column drive is registered so the pins never glitch on index wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      key_row   <= 2'd0;
      deb_cnt   <= '0;
      col_out   <= 4'b1110;
      key_event <= 1'b0;
      key_value <= 4'h0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      key_row   <= key_row_n;
      deb_cnt   <= deb_cnt_n;
      col_out   <= ~(4'b0001 << col_idx_n);
      key_event <= event_n;
      key_value <= value_n;
    end
  end

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: scans/debounces the keypad and assembles accepted keys
// into a fixed-length hex code with submit, clear and idle-timeout handling.
module keypad_code_entry
  import keypad_code_entry_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int DEBOUNCE    = 4,
  parameter int CODE_DIGITS = 4,
  parameter int TIMEOUT     = 500000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               row_in,
  output logic [3:0]               col_out,
  output logic                     key_event,
  output logic [3:0]               key_value,
  output logic [2:0]               digit_count,
  output logic [4*CODE_DIGITS-1:0] code,
  output logic                     code_valid,
  output logic                     code_err
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(TIMEOUT);
  localparam logic [2:0]        DIGITS_FULL = 3'(CODE_DIGITS);

  logic [4*CODE_DIGITS-1:0] code_buf;
  logic [IDLE_W-1:0]        idle_cnt;
  logic                     full;

  assign full = (digit_count == DIGITS_FULL);

  keypad_debounce_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_event (key_event),
    .key_value (key_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_buf    <= '0;
      digit_count <= 3'd0;
      code        <= '0;
      code_valid  <= 1'b0;
      code_err    <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      code_valid <= 1'b0;
      code_err   <= 1'b0;
      if (key_event) begin
        idle_cnt <= '0;
        if (key_value == KEY_CLR) begin
          code_buf    <= '0;
          digit_count <= 3'd0;
        end else if (key_value == KEY_ENT) begin
          if (full) begin
            code       <= code_buf;
            code_valid <= 1'b1;
          end else begin
            code_err <= 1'b1;
          end
          code_buf    <= '0;
          digit_count <= 3'd0;
        end else if (!full) begin
          code_buf    <= {code_buf[4*CODE_DIGITS-5:0], key_value};
          digit_count <= digit_count + 1'b1;
        end
      end else begin
        // Idle counter saturates; a stale partial entry is dropped silently.
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
        if (idle_cnt == IDLE_MAX && digit_count != 3'd0) begin
          code_buf    <= '0;
          digit_count <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Scoreboard bench for keypad_code_entry: a keypad matrix model drives rows,
// expected keys and strobes are queued at stimulus time and checked on output.
module tb_keypad_code_entry;
  localparam int SCAN_DIV    = 4;
  localparam int DEBOUNCE    = 3;
  localparam int CODE_DIGITS = 4;
  localparam int TIMEOUT     = 200;

  typedef struct {
    logic        is_err;
    logic [15:0] code;
  } strobe_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_event;
  logic [3:0]  key_value;
  logic [2:0]  digit_count;
  logic [15:0] code;
  logic        code_valid;
  logic        code_err;

  logic [15:0] pressed = 16'h0;
  logic [3:0]  key_q[$];
  strobe_t     strobe_q[$];
  logic [15:0] m_buf = 16'h0;
  logic [15:0] m_code = 16'h0;
  int          m_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          ev_cnt = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  time         last_ev_time = 0;

  keypad_code_entry #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE    (DEBOUNCE),
    .CODE_DIGITS (CODE_DIGITS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_event   (key_event),
    .key_value   (key_value),
    .digit_count (digit_count),
    .code        (code),
    .code_valid  (code_valid),
    .code_err    (code_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic int pos_of(input logic [3:0] v);
    int p;
    case (v)
      4'h1: p = 0;  4'h2: p = 1;  4'h3: p = 2;  4'hA: p = 3;
      4'h4: p = 4;  4'h5: p = 5;  4'h6: p = 6;  4'hB: p = 7;
      4'h7: p = 8;  4'h8: p = 9;  4'h9: p = 10; 4'hC: p = 11;
      4'hE: p = 12; 4'h0: p = 13; 4'hF: p = 14; default: p = 15;
    endcase
    return p;
  endfunction

  task automatic model_key(input logic [3:0] v);
    strobe_t s;
    key_q.push_back(v);
    if (v == 4'hE) begin
      m_buf = 16'h0; m_cnt = 0;
    end else if (v == 4'hF) begin
      s.is_err = (m_cnt != CODE_DIGITS);
      if (!s.is_err) m_code = m_buf;
      s.code = m_code;
      strobe_q.push_back(s);
      m_buf = 16'h0; m_cnt = 0;
    end else if (m_cnt < CODE_DIGITS) begin
      m_buf = {m_buf[11:0], v}; m_cnt++;
    end
  endtask

  task automatic monitor();
    logic    prev_ev;
    logic    [3:0] ek;
    strobe_t es;
    prev_ev = 1'b0;
    forever begin
      @(negedge clk);
      if (key_event) begin
        checks++; ev_cnt++; last_ev_time = $time;
        if (prev_ev) begin
          errors++; $display("FAIL key_event_width: high for 2+ cycles, required 1");
        end else if (key_q.size() == 0) begin
          errors++; $display("FAIL key_event_unexpected: value %h, none expected", key_value);
        end else begin
          ek = key_q.pop_front();
          if (key_value !== ek) begin
            errors++; $display("FAIL key_value: got %h, expected %h", key_value, ek);
          end
        end
      end
      if (code_valid || code_err) begin
        checks++;
        if (code_valid) valid_cnt++;
        if (code_err) err_cnt++;
        if (code_valid && code_err) begin
          errors++; $display("FAIL strobe_overlap: code_valid and code_err both high");
        end else if (strobe_q.size() == 0) begin
          errors++; $display("FAIL strobe_unexpected: valid=%b err=%b, none expected", code_valid, code_err);
        end else begin
          es = strobe_q.pop_front();
          if (code_err !== es.is_err || code !== es.code) begin
            errors++;
            $display("FAIL strobe: got err=%b code=%h, expected err=%b code=%h", code_err, code, es.is_err, es.code);
          end
        end
      end
      prev_ev = key_event;
    end
  endtask

  task automatic press(input logic [3:0] v, input int hold = 40, input int rel = 40);
    model_key(v);
    @(negedge clk);
    pressed[pos_of(v)] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = 16'h0;
    repeat (rel) @(negedge clk);
    checks++;
    if (digit_count !== 3'(m_cnt)) begin
      errors++; $display("FAIL digit_count after key %h: got %0d, expected %0d", v, digit_count, m_cnt);
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (key_q.size() != 0 || strobe_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_outputs: %0d keys and %0d strobes outstanding, expected 0", name, key_q.size(), strobe_q.size());
    end
    key_q.delete();
    strobe_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (col_out !== 4'b1110 || key_event !== 1'b0 || key_value !== 4'h0 || digit_count !== 3'd0 ||
        code !== 16'h0 || code_valid !== 1'b0 || code_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: col=%b ev=%b val=%h cnt=%0d code=%h v=%b e=%b, expected 1110 0 0 0 0000 0 0",
               name, col_out, key_event, key_value, digit_count, code, code_valid, code_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_code_entry();
    int v0;
    v0 = valid_cnt;
    press(4'h1); press(4'h0); press(4'h1); press(4'h0); press(4'hF);
    drain("code_entry");
    checks++;
    if (code !== 16'h1010 || valid_cnt - v0 != 1) begin
      errors++; $display("FAIL code_entry: code=%h pulses=%0d, expected 1010 and 1", code, valid_cnt - v0);
    end
  endtask

  task automatic test_short_submit();
    int e0;
    e0 = err_cnt;
    press(4'h5); press(4'h5); press(4'hF);
    drain("short_submit");
    checks++;
    if (code !== 16'h1010 || err_cnt - e0 != 1) begin
      errors++; $display("FAIL short_submit: code=%h err_pulses=%0d, expected 1010 and 1", code, err_cnt - e0);
    end
  endtask

  task automatic test_bounce();
    int  n0;
    time stable_at;
    n0 = ev_cnt;
    model_key(4'h5);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      pressed[5] = ~pressed[5];
      repeat (3) @(negedge clk);
    end
    pressed[5] = 1'b1;
    stable_at = $time;
    repeat (40) @(negedge clk);
    pressed = 16'h0;
    repeat (40) @(negedge clk);
    drain("bounce");
    checks++;
    if (ev_cnt - n0 != 1 || last_ev_time < stable_at) begin
      errors++;
      $display("FAIL bounce: events=%0d at %0t, expected 1 after %0t", ev_cnt - n0, last_ev_time, stable_at);
    end
  endtask

  task automatic test_multi_and_hold();
    int n0;
    model_key(4'h2);
    @(negedge clk);
    pressed[pos_of(4'h2)] = 1'b1;
    pressed[pos_of(4'h8)] = 1'b1;
    repeat (40) @(negedge clk);
    pressed = 16'h0;
    repeat (40) @(negedge clk);
    drain("multi_key");
    n0 = ev_cnt;
    press(4'hE, 1000, 40);
    drain("long_hold");
    checks++;
    if (ev_cnt - n0 != 1) begin
      errors++; $display("FAIL long_hold: events=%0d, expected 1", ev_cnt - n0);
    end
  endtask

  task automatic test_timeout();
    int s0;
    press(4'h3); press(4'h7);
    s0 = valid_cnt + err_cnt;
    repeat (TIMEOUT) @(negedge clk);
    m_buf = 16'h0; m_cnt = 0;
    checks++;
    if (digit_count !== 3'd0 || valid_cnt + err_cnt != s0) begin
      errors++;
      $display("FAIL timeout: digit_count=%0d strobes=%0d, expected 0 and 0", digit_count, valid_cnt + err_cnt - s0);
    end
    press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'h4); press(4'hF);
    drain("overflow");
    checks++;
    if (code !== 16'h9999) begin
      errors++; $display("FAIL overflow_code: got %h, expected 9999", code);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pressed[pos_of(4'h1)] = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    m_buf = 16'h0; m_cnt = 0; m_code = 16'h0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_mid");
    model_key(4'h1);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    pressed = 16'h0;
    repeat (40) @(negedge clk);
    drain("reset_mid_repress");
    checks++;
    if (digit_count !== 3'd1) begin
      errors++; $display("FAIL reset_mid_count: got %0d, expected 1", digit_count);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_code_entry();
    test_short_submit();
    test_bounce();
    test_multi_and_hold();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
